// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/grant/response, redirect input,
// and the decoded-instruction valid/ready output toward the decoder.
interface inst_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, op, funct3, funct7,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, op, funct3, funct7,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: word requests to imem, 2-entry {pc,word} buffer, redirect flush.
// Latency grant->inst_valid is 2 cycles (no bypass); fetch stalls once in-flight + buffered reaches 2.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  logic [31:0] fetch_pc;
  logic [1:0]  inflight;
  logic [1:0]  discard;
  logic [31:0] pcq [2];
  logic        pcq_wr;
  logic        pcq_rd;
  entry_t      fifo [2];
  logic        fifo_head;
  logic [1:0]  fifo_cnt;

  logic        valid_int;
  logic        pop;
  logic [2:0]  occ;
  logic        req;
  logic        grant;
  logic        resp;
  logic        keep;
  logic [31:0] redirect_tgt;
  entry_t      head;

  assign valid_int    = (fifo_cnt != 2'd0) && !bus.redirect;
  assign pop          = valid_int && bus.inst_ready;
  // Pop frees a slot combinationally so a 1-cycle memory can sustain one word per cycle.
  assign occ          = {1'b0, inflight} + {1'b0, fifo_cnt} - {2'b00, pop};
  assign req          = rst_n && !bus.redirect && (occ < 3'd2);
  assign grant        = req && bus.imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp         = bus.imem_rvalid && (inflight != 2'd0);
  assign keep         = resp && (discard == 2'd0) && !bus.redirect;
  assign redirect_tgt = bus.redirect_pc & ~32'h3;
  assign head         = fifo[fifo_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      inflight  <= 2'd0;
      discard   <= 2'd0;
      pcq[0]    <= '0;
      pcq[1]    <= '0;
      pcq_wr    <= 1'b0;
      pcq_rd    <= 1'b0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      fifo_head <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else begin
      if (grant) begin
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= ~pcq_wr;
      end
      if (resp) begin
        pcq_rd <= ~pcq_rd;
      end
      inflight <= inflight + {1'b0, grant} - {1'b0, resp};

      if (bus.redirect) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetch_pc <= redirect_tgt;
        fifo_cnt <= 2'd0;
        discard  <= inflight - {1'b0, resp};
      end else begin
        if (grant) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (resp && (discard != 2'd0)) begin
          discard <= discard - 2'd1;
        end
        if (keep) begin
          fifo[fifo_head ^ fifo_cnt[0]] <= '{pc: pcq[pcq_rd], word: bus.imem_rdata};
        end
        if (pop) begin
          fifo_head <= ~fifo_head;
        end
        fifo_cnt <= fifo_cnt + {1'b0, keep} - {1'b0, pop};
      end
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = valid_int;
  assign bus.inst       = valid_int ? head.word : 32'h0000_0013;
  assign bus.inst_pc    = valid_int ? head.pc : 32'h0000_0000;
  assign bus.op         = bus.inst[6:0];
  assign bus.funct3     = bus.inst[14:12];
  assign bus.funct7     = bus.inst[31:25];

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the RISC-V core, the producer side of the instruction decoder's op/funct3/funct7 inputs. Holds the fetch PC and issues word requests to instruction memory over a request/grant/response interface. Buffers up to two instructions and presents them with a valid/ready handshake, already split into decoder fields. Handles jump/branch redirects by flushing buffered and in-flight instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- redirect  in  1  jump/branch taken; restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  instruction available
- inst_ready  in  1  downstream consumes instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst
- op  out  7  inst[6:0]
- funct3  out  3  inst[14:12]
- funct7  out  7  inst[31:25]

## Operation
- State: fetch_pc (32), in-flight count (0..2), discard count (0..2), 2-entry PC queue for in-flight requests, 2-entry instruction FIFO of {pc, word}.
- pop = inst_valid && inst_ready.
- imem_req = !redirect && (inflight + fifo_count - pop) < 2. inflight includes requests marked for discard. imem_addr = fetch_pc at all times.
- Grant (imem_req && imem_gnt): push fetch_pc onto PC queue, fetch_pc += 4 (wraps modulo 2^32), inflight += 1.
- Response (imem_rvalid): inflight -= 1, pop PC queue. If discard > 0, then discard -= 1 and the word is dropped. Otherwise push {queued pc, imem_rdata} into the FIFO.
- imem_rvalid with inflight == 0 is a protocol error; it is ignored and leaves state unchanged.
- inst_valid = (fifo_count > 0) && !redirect. inst/inst_pc are the FIFO head. op/funct3/funct7 are slices of inst.
- When inst_valid = 0: inst = 32'h0000_0013 (addi x0,x0,0), so op = 7'b0010011, funct3 = 0, funct7 = 0, and inst_pc = 0.
- Redirect cycle (highest priority):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - FIFO flushed; no pop occurs.
  - Any response arriving this cycle is dropped.
  - discard <= inflight remaining after this cycle's response.
  - No request is issued.
- Back-to-back redirects: the last one wins. Discard accumulates correctly because each redirect resamples the remaining inflight count.
- The FIFO never overflows by construction. Simultaneous push and pop is allowed at any occupancy.

## Timing
- Reset (rst_n = 0, asynchronous): fetch_pc = RESET_PC, all counts 0, FIFO empty, imem_req = 0, imem_addr = RESET_PC, inst_valid = 0, inst = 32'h13, inst_pc = 0.
- First request: imem_req = 1 in the first cycle after rst_n deasserts.
- Latency: with a 1-cycle memory, grant in cycle N, rvalid in N+1, inst_valid in N+2. There is no bypass from imem_rdata to inst.
- Throughput: 1 instruction/cycle sustained with a 1-cycle memory and inst_ready held high. This relies on the combinational inst_ready -> imem_req path.
- Redirect: the first request to the new PC is issued the cycle after redirect. With a 1-cycle memory, the first new instruction is valid 3 cycles after redirect.
- inst_ready low: outputs hold stable while inst_valid = 1. Fetch stalls once inflight + fifo_count = 2.
- Reset mid-operation: all in-flight responses after reset release are treated as protocol errors. The memory must be reset with the same rst_n.

## Test plan
- Reset then stream: RESET_PC = 0x100, 1-cycle memory, inst_ready = 1.
  - Requests 0x100, 0x104, 0x108… on consecutive cycles.
  - inst_valid first high 2 cycles after the first grant, then every cycle.
  - inst_pc tracks the request addresses.
- Field split: memory returns 0x4000_5033 -> op = 0110011, funct3 = 101, funct7 = 0100000. Idle output is 0x13 with op = 0010011.
- Backpressure: hold inst_ready = 0 for 5 cycles.
  - Exactly 2 grants occur, then imem_req = 0.
  - inst holds the first word.
  - On release, the words drain in order with no loss or duplication.
- Redirect with 2 in flight: 3-cycle memory, redirect to 0x2003.
  - Both old responses are dropped.
  - Next imem_addr = 0x2000.
  - The first valid instruction has inst_pc = 0x2000.
- Back-to-back redirects to 0x40 then 0x80: only the 0x80 stream appears. No 0x40 instructions are delivered.
- Wrap: RESET_PC = 0xFFFF_FFFC -> second request address is 0x0000_0000.
